key_uart_sched: RTL and testbench
=================================

// Module: key_uart_sched
// PURPOSE
//  Schedules byte transmissions from two byte sources (key counter, second source)
//  onto the single UART byte transmitter. Holds one pending byte per requester,
//  arbitrates round-robin into a small FIFO, then sequences the TX:
//  one-cycle Send_en pulse, then wait for Tx_Done, with a timeout.
//  Sits between the key counter/control logic and the UART byte TX.
// PARAMETERS
//  FIFO_AW     2      FIFO address width; depth = 2**FIFO_AW (4)
//  TX_TIMEOUT  65535  cycles to wait for Tx_Done before abandoning the byte
// PORTS
//  Clk        in   1  system clock, all logic on posedge
//  Rst_n      in   1  asynchronous active-low reset
//  req0_en    in   1  one-cycle strobe: req0_byte valid (key counter)
//  req0_byte  in   8  byte from requester 0
//  req1_en    in   1  one-cycle strobe: req1_byte valid
//  req1_byte  in   8  byte from requester 1
//  Tx_Done    in   1  one-cycle pulse from UART TX: byte finished
//  Send_en    out  1  one-cycle start pulse to UART TX
//  Data_byte  out  8  byte to UART TX, stable from Send_en until Tx_Done/timeout
//  busy       out  1  FSM not in IDLE
//  fifo_full  out  1  FIFO holds 2**FIFO_AW entries
//  drop_cnt   out  8  saturating count of discarded request bytes
//  tmo_err    out  1  sticky: a transmission timed out; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, pend0/pend1 empty, rr pointer = req0, FSM IDLE.
//  Pending stage: reqN_en loads pendN (byte+valid) on the next edge.
//   reqN_en while pendN valid and not granted that cycle -> new byte overwrites,
//   drop_cnt +1. Granted same cycle -> new byte accepted, no drop.
//  Arbiter: at most one pending written to FIFO per cycle, only if !fifo_full.
//   Both pending valid -> grant rr side, rr flips to the other; one valid -> grant it.
//   rr changes only on a grant made while both were pending.
//  FIFO: FIFO_AW+1-bit rd/wr pointers; full = MSBs differ, low bits equal.
//   Simultaneous push and pop when full is legal (pop frees slot the same edge).
//  Drops: a byte overwritten in pendN counts; drop_cnt saturates at 8'hFF.
//  FSM (registered):
//   IDLE: FIFO non-empty -> pop; head latched into Data_byte; -> SEND.
//   SEND: Send_en=1 this cycle only; tmo counter cleared; -> WAIT.
//   WAIT: Tx_Done -> IDLE. Counter reaches TX_TIMEOUT -> tmo_err=1, -> IDLE.
//         Tx_Done in SEND is ignored (not a valid completion).
//  Latency: reqN_en at cycle 0, pend/FIFO/FSM idle and empty -> pend valid c1,
//   FIFO write c1->c2, IDLE pop c2, Send_en high c3.
//  Back-to-back: after Tx_Done, next Send_en >= 2 cycles later (IDLE, SEND).
//  Counter width: 16 bits for the default; must hold TX_TIMEOUT.
//  Reset mid-transfer: immediate return to reset state; queued/pending bytes lost.
// STRUCTURE
//  Shared package/header: FSM state encodings (IDLE=2'd0, SEND=2'd1, WAIT=2'd2),
//   default FIFO_AW and TX_TIMEOUT.
//  One sub-module: sync_fifo (W=8, AW=FIFO_AW; push/pop/full/empty/dout).
//   Arbiter, pending regs and FSM stay in this module.
// TESTING
//  1 Single: req0_en byte 8'h05, Tx_Done 10 cycles after Send_en
//    -> Send_en 3 cycles after strobe, Data_byte=8'h05, busy then idle.
//  2 Simultaneous: req0 8'hA1 and req1 8'hB2 same cycle, then repeat 8'hA3/8'hB4
//    -> TX order A1, B2, B4, A3 (rr alternates); drop_cnt=0.
//  3 Overflow: Tx_Done held off, 8 req0 strobes one per cycle
//    -> fifo_full=1 after 4 entries, pend0 holds 1, drop_cnt=3.
//  4 Timeout: one byte, never pulse Tx_Done, TX_TIMEOUT=16
//    -> tmo_err=1 after 16 WAIT cycles, FSM back to IDLE, next byte sent.
//  5 Reset mid-WAIT with 3 bytes queued -> all outputs 0, no Send_en after
//    release until a new strobe.
//  6 Spurious Tx_Done in SEND cycle -> ignored; completes only on later Tx_Done.

Source files
------------

// File: rtl/key_uart_sched_pkg.sv
// Shared encodings and defaults for the key/second-source UART byte scheduler.
package key_uart_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam int FIFO_AW_DEF    = 2;
  localparam int TX_TIMEOUT_DEF = 65535;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } pend_t;

endpackage

// File: rtl/key_uart_sched_sync_fifo.sv
// Small synchronous FIFO; extra pointer MSB distinguishes full from empty.
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [2**AW];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop on the same edge frees the slot, so a push into a full FIFO is legal then
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/key_uart_sched.sv
// Round-robin scheduler of two byte sources onto one UART byte transmitter.
//  state | meaning
//  IDLE  | waiting for a queued byte; pops FIFO head into Data_byte
//  SEND  | one-cycle Send_en pulse, timeout counter cleared
//  WAIT  | waiting for Tx_Done or timeout (sets sticky tmo_err)
module key_uart_sched
  import key_uart_sched_pkg::*;
#(
  parameter int FIFO_AW    = FIFO_AW_DEF,
  parameter int TX_TIMEOUT = TX_TIMEOUT_DEF
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       req0_en,
  input  logic [7:0] req0_byte,
  input  logic       req1_en,
  input  logic [7:0] req1_byte,
  input  logic       Tx_Done,
  output logic       Send_en,
  output logic [7:0] Data_byte,
  output logic       busy,
  output logic       fifo_full,
  output logic [7:0] drop_cnt,
  output logic       tmo_err
);

  localparam int CW = $clog2(TX_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_TERM = CW'(TX_TIMEOUT - 1);

  pend_t       pend0;
  pend_t       pend1;
  logic        rr;
  logic        gnt0;
  logic        gnt1;
  logic        push;
  logic [7:0]  push_data;
  logic        pop;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        drop0;
  logic        drop1;
  logic [8:0]  drop_sum;
  logic [1:0]  state;
  logic [CW-1:0] tmo_cnt;

  // rr == 0 favours requester 0 when both are pending
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!fifo_full) begin
      if (pend0.vld && (!pend1.vld || !rr)) gnt0 = 1'b1;
      else if (pend1.vld)                   gnt1 = 1'b1;
    end
  end

  assign push      = gnt0 || gnt1;
  assign push_data = gnt0 ? pend0.data : pend1.data;
  assign drop0     = req0_en && pend0.vld && !gnt0;
  assign drop1     = req1_en && pend1.vld && !gnt1;
  assign drop_sum  = {1'b0, drop_cnt} + {8'd0, drop0} + {8'd0, drop1};
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign Send_en   = (state == ST_SEND);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pend0    <= '0;
      pend1    <= '0;
      rr       <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (req0_en)   pend0 <= {1'b1, req0_byte};
      else if (gnt0) pend0.vld <= 1'b0;
      if (req1_en)   pend1 <= {1'b1, req1_byte};
      else if (gnt1) pend1.vld <= 1'b0;
      if (push && pend0.vld && pend1.vld) rr <= ~rr;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  sync_fifo #(
    .W  (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= ST_IDLE;
      Data_byte <= '0;
      tmo_cnt   <= '0;
      tmo_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            Data_byte <= fifo_dout;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (Tx_Done) begin
            state <= ST_IDLE;
          end else if (tmo_cnt == TMO_TERM) begin
            tmo_err <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_uart_sched.sv
// Directed self-checking bench for key_uart_sched (FIFO depth 4, timeout 16).
module tb_key_uart_sched;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       req0_en;
  logic [7:0] req0_byte;
  logic       req1_en;
  logic [7:0] req1_byte;
  logic       Tx_Done;
  logic       Send_en;
  logic [7:0] Data_byte;
  logic       busy;
  logic       fifo_full;
  logic [7:0] drop_cnt;
  logic       tmo_err;

  int checks = 0;
  int errors = 0;

  key_uart_sched #(
    .FIFO_AW    (2),
    .TX_TIMEOUT (16)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .req0_en   (req0_en),
    .req0_byte (req0_byte),
    .req1_en   (req1_en),
    .req1_byte (req1_byte),
    .Tx_Done   (Tx_Done),
    .Send_en   (Send_en),
    .Data_byte (Data_byte),
    .busy      (busy),
    .fifo_full (fifo_full),
    .drop_cnt  (drop_cnt),
    .tmo_err   (tmo_err)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Rst_n = 1'b0;
    req0_en = 1'b0; req0_byte = 8'h00;
    req1_en = 1'b0; req1_byte = 8'h00;
    Tx_Done = 1'b0;
    step();
    step();
    Rst_n = 1'b1;
    step();
  endtask

  // steps until Send_en is seen (current cycle included); n = cycles stepped
  task automatic wait_send(input int budget, output bit got, output int n);
    got = 1'b0;
    n = 0;
    while (!got && n < budget) begin
      if (Send_en) got = 1'b1;
      else begin
        step();
        n++;
      end
    end
  endtask

  // called in the SEND cycle: Tx_Done on the first WAIT cycle, returns in IDLE
  task automatic finish_tx();
    step();
    Tx_Done = 1'b1;
    step();
    Tx_Done = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    req0_en = 1'b0; req0_byte = 8'h00;
    req1_en = 1'b0; req1_byte = 8'h00;
    Tx_Done = 1'b0;
    step();
    step();
    checks++;
    if ({Send_en, Data_byte, busy, fifo_full, drop_cnt, tmo_err} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {Send_en, Data_byte, busy, fifo_full, drop_cnt, tmo_err});
    end
    Rst_n = 1'b1;
    step();
    step();
    checks++;
    if (Send_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: Send_en=%b busy=%b expected 0 0", Send_en, busy);
    end
  endtask

  task automatic test_single();
    bit bad;
    apply_reset();
    req0_en = 1'b1; req0_byte = 8'h05;
    step();
    req0_en = 1'b0;
    checks++;
    if (Send_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_c1: Send_en=%b busy=%b expected 0 0", Send_en, busy);
    end
    step();
    checks++;
    if (Send_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_c2: Send_en=%b busy=%b expected 0 0", Send_en, busy);
    end
    step();
    checks++;
    if (Send_en !== 1'b1 || Data_byte !== 8'h05 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_c3: Send_en=%b Data_byte=%h busy=%b expected 1 05 1",
               Send_en, Data_byte, busy);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (Send_en !== 1'b0 || busy !== 1'b1 || Data_byte !== 8'h05) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL single_wait: Send_en/busy/Data_byte wrong during WAIT, expected 0/1/05");
    end
    Tx_Done = 1'b1;
    step();
    Tx_Done = 1'b0;
    checks++;
    if (busy !== 1'b0 || Data_byte !== 8'h05 || tmo_err !== 1'b0) begin
      errors++;
      $display("FAIL single_done: busy=%b Data_byte=%h tmo_err=%b expected 0 05 0",
               busy, Data_byte, tmo_err);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] got_b [4];
    logic [7:0] exp_b [4];
    bit got;
    int n;
    exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hB4; exp_b[3] = 8'hA3;
    apply_reset();
    req0_en = 1'b1; req0_byte = 8'hA1;
    req1_en = 1'b1; req1_byte = 8'hB2;
    step();
    req0_en = 1'b0; req1_en = 1'b0;
    step();
    step();
    checks++;
    if (Send_en !== 1'b1) begin
      errors++;
      $display("FAIL rr_first_send: Send_en=%b expected 1", Send_en);
    end
    got_b[0] = Data_byte;
    req0_en = 1'b1; req0_byte = 8'hA3;
    req1_en = 1'b1; req1_byte = 8'hB4;
    step();
    req0_en = 1'b0; req1_en = 1'b0;
    Tx_Done = 1'b1;
    step();
    Tx_Done = 1'b0;
    for (int i = 1; i < 4; i++) begin
      wait_send(20, got, n);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL rr_send_%0d: no Send_en within 20 cycles", i);
        got_b[i] = 8'hXX;
      end else begin
        got_b[i] = Data_byte;
        if (i == 1) begin
          checks++;
          if (n != 1) begin
            errors++;
            $display("FAIL back_to_back: Send_en %0d cycles after IDLE, expected 1", n);
          end
        end
        finish_tx();
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_b[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL rr_order_%0d: got %h expected %h", i, got_b[i], exp_b[i]);
      end
    end
    checks++;
    if (drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rr_drop_cnt: got %0d expected 0", drop_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_b [5];
    bit got;
    int n;
    exp_b[0] = 8'h20; exp_b[1] = 8'h21; exp_b[2] = 8'h22; exp_b[3] = 8'h23; exp_b[4] = 8'h27;
    apply_reset();
    req0_en = 1'b1; req0_byte = 8'h10;
    step();
    req0_en = 1'b0;
    step();
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      req0_en = 1'b1;
      req0_byte = 8'h20 + 8'(i);
      step();
    end
    req0_en = 1'b0;
    checks++;
    if (fifo_full !== 1'b1 || drop_cnt !== 8'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL overflow_state: fifo_full=%b drop_cnt=%0d busy=%b expected 1 3 1",
               fifo_full, drop_cnt, busy);
    end
    Tx_Done = 1'b1;
    step();
    Tx_Done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_send(20, got, n);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL overflow_send_%0d: no Send_en within 20 cycles", i);
      end else if (Data_byte !== exp_b[i]) begin
        errors++;
        $display("FAIL overflow_order_%0d: got %h expected %h", i, Data_byte, exp_b[i]);
      end
      if (got) finish_tx();
    end
    checks++;
    if (fifo_full !== 1'b0 || drop_cnt !== 8'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drain: fifo_full=%b drop_cnt=%0d busy=%b expected 0 3 0",
               fifo_full, drop_cnt, busy);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    req0_en = 1'b1; req0_byte = 8'h44;
    step();
    req0_byte = 8'h55;
    step();
    req0_en = 1'b0;
    step();
    checks++;
    if (Send_en !== 1'b1 || Data_byte !== 8'h44) begin
      errors++;
      $display("FAIL tmo_send: Send_en=%b Data_byte=%h expected 1 44", Send_en, Data_byte);
    end
    repeat (16) step();
    checks++;
    if (tmo_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_last_wait: tmo_err=%b busy=%b expected 0 1", tmo_err, busy);
    end
    step();
    checks++;
    if (tmo_err !== 1'b1 || busy !== 1'b0 || Send_en !== 1'b0) begin
      errors++;
      $display("FAIL tmo_fire: tmo_err=%b busy=%b Send_en=%b expected 1 0 0",
               tmo_err, busy, Send_en);
    end
    step();
    checks++;
    if (Send_en !== 1'b1 || Data_byte !== 8'h55) begin
      errors++;
      $display("FAIL tmo_next: Send_en=%b Data_byte=%h expected 1 55", Send_en, Data_byte);
    end
    finish_tx();
    checks++;
    if (tmo_err !== 1'b1 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL tmo_sticky: tmo_err=%b drop_cnt=%0d expected 1 0", tmo_err, drop_cnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit bad;
    bit got;
    int n;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      req0_en = 1'b1;
      req0_byte = 8'h61 + 8'(i);
      step();
    end
    req0_en = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b1 || Data_byte !== 8'h61) begin
      errors++;
      $display("FAIL rst_pre: busy=%b Data_byte=%h expected 1 61", busy, Data_byte);
    end
    Rst_n = 1'b0;
    #1;
    checks++;
    if ({Send_en, Data_byte, busy, fifo_full, drop_cnt, tmo_err} !== 20'h0) begin
      errors++;
      $display("FAIL rst_async: got %h expected 0",
               {Send_en, Data_byte, busy, fifo_full, drop_cnt, tmo_err});
    end
    step();
    Rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (Send_en !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_quiet: Send_en or busy seen after reset release, expected 0");
    end
    req1_en = 1'b1; req1_byte = 8'h77;
    step();
    req1_en = 1'b0;
    wait_send(10, got, n);
    checks++;
    if (!got || n != 2 || Data_byte !== 8'h77) begin
      errors++;
      $display("FAIL rst_new: got=%b delay=%0d Data_byte=%h expected 1 2 77", got, n, Data_byte);
    end
    if (got) finish_tx();
  endtask

  task automatic test_spurious_done();
    apply_reset();
    req0_en = 1'b1; req0_byte = 8'h88;
    step();
    req0_en = 1'b0;
    step();
    step();
    checks++;
    if (Send_en !== 1'b1) begin
      errors++;
      $display("FAIL spur_send: Send_en=%b expected 1", Send_en);
    end
    Tx_Done = 1'b1;
    step();
    Tx_Done = 1'b0;
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL spur_ignored: busy=%b expected 1", busy);
    end
    Tx_Done = 1'b1;
    step();
    Tx_Done = 1'b0;
    checks++;
    if (busy !== 1'b0 || tmo_err !== 1'b0 || Data_byte !== 8'h88) begin
      errors++;
      $display("FAIL spur_done: busy=%b tmo_err=%b Data_byte=%h expected 0 0 88",
               busy, tmo_err, Data_byte);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_timeout();
    test_reset_mid_wait();
    test_spurious_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
